// File: rtl/control_pkg.sv
// ---------------------------------------------------------------------------
// control_pkg
// Shared definitions for the main control decoder: supported opcodes,
// ALUOp class encodings and the packed nine-bit control vector.
// Field order of ctrl_t, MSB first:
//   {reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch,
//    alu_op[1:0]}
// ---------------------------------------------------------------------------
package control_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic [1:0] alu_op;
  } ctrl_t;

  // All strobes low: no register write, no memory access.
  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/control_decode.sv
// ---------------------------------------------------------------------------
// control_decode
// Purely combinational opcode decode into the control vector plus an
// illegal-opcode flag. Unsupported opcodes (including X/Z in simulation,
// which match no case item) produce an all-zero vector with o_illegal = 1.
// Ports:
//   i_op      in  [6:0]  instruction opcode, instr[6:0]
//   o_ctrl    out ctrl_t control vector
//   o_illegal out 1      opcode not supported
// ---------------------------------------------------------------------------
module control_decode
  import control_pkg::*;
(
  input  logic [6:0] i_op,
  output ctrl_t      o_ctrl,
  output logic       o_illegal
);

  always_comb begin
    o_ctrl    = CTRL_NOP;
    o_illegal = 1'b1;
    case (i_op)
      OP_RTYPE: begin
        o_ctrl.reg_dst   = 1'b1;
        o_ctrl.reg_write = 1'b1;
        o_ctrl.alu_op    = ALUOP_FUNCT;
        o_illegal        = 1'b0;
      end
      OP_LOAD: begin
        o_ctrl.alu_src    = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_read   = 1'b1;
        o_ctrl.alu_op     = ALUOP_ADD;
        o_illegal         = 1'b0;
      end
      OP_STORE: begin
        // mem_to_reg is held at 0 rather than left as don't-care.
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.mem_write = 1'b1;
        o_ctrl.alu_op    = ALUOP_ADD;
        o_illegal        = 1'b0;
      end
      OP_BRANCH: begin
        o_ctrl.branch = 1'b1;
        o_ctrl.alu_op = ALUOP_SUB;
        o_illegal     = 1'b0;
      end
      default: begin
        o_ctrl    = CTRL_NOP;
        o_illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// ---------------------------------------------------------------------------
// control_unit
// Main control decoder for the single-cycle RISC-V datapath. Decodes the
// opcode into datapath strobes and ALUOp, flags unsupported opcodes and
// keeps a sticky record of any illegal opcode seen since reset.
//
// Build option:
//   CONTROL_UNIT_OUT_REG_EN  defined   -> strobes and Illegal registered
//                                         (one-cycle latency, reset to 0)
//                            undefined -> strobes and Illegal combinational
//
// Ports:
//   clk            in   system clock (sticky flag, optional output register)
//   rst_n          in   asynchronous active-low reset
//   Op             in   [6:0] instruction opcode
//   RegDst         out  destination-register select
//   ALUSrc         out  ALU operand B: 1 = immediate, 0 = register
//   MemToReg       out  write-back source: 1 = memory, 0 = ALU
//   RegWrite       out  register-file write enable
//   MemRead        out  data-memory read enable
//   MemWrite       out  data-memory write enable
//   Branch         out  conditional-branch instruction
//   ALUOp1/ALUOp0  out  ALU class: 00 add, 01 sub/compare, 10 funct
//   Illegal        out  current opcode unsupported
//   IllegalSticky  out  an illegal opcode has been seen since reset
// ---------------------------------------------------------------------------
module control_unit
  import control_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] Op,
  output logic       RegDst,
  output logic       ALUSrc,
  output logic       MemToReg,
  output logic       RegWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       Branch,
  output logic       ALUOp1,
  output logic       ALUOp0,
  output logic       Illegal,
  output logic       IllegalSticky
);

  ctrl_t w_ctrl;
  logic  w_illegal;
  ctrl_t w_ctrl_out;
  logic  w_illegal_out;
  logic  r_sticky;

  control_decode u_decode (
    .i_op      (Op),
    .o_ctrl    (w_ctrl),
    .o_illegal (w_illegal)
  );

`ifdef CONTROL_UNIT_OUT_REG_EN
  ctrl_t r_ctrl;
  logic  r_illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl    <= CTRL_NOP;
      r_illegal <= 1'b0;
    end else begin
      r_ctrl    <= w_ctrl;
      r_illegal <= w_illegal;
    end
  end

  assign w_ctrl_out    = r_ctrl;
  assign w_illegal_out = r_illegal;
`else
  assign w_ctrl_out    = w_ctrl;
  assign w_illegal_out = w_illegal;
`endif

  // Sticky follows the visible Illegal, so in the registered build it sets
  // one cycle after the registered flag rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky <= 1'b0;
    end else if (w_illegal_out) begin
      r_sticky <= 1'b1;
    end
  end

  assign RegDst        = w_ctrl_out.reg_dst;
  assign ALUSrc        = w_ctrl_out.alu_src;
  assign MemToReg      = w_ctrl_out.mem_to_reg;
  assign RegWrite      = w_ctrl_out.reg_write;
  assign MemRead       = w_ctrl_out.mem_read;
  assign MemWrite      = w_ctrl_out.mem_write;
  assign Branch        = w_ctrl_out.branch;
  assign ALUOp1        = w_ctrl_out.alu_op[1];
  assign ALUOp0        = w_ctrl_out.alu_op[0];
  assign Illegal       = w_illegal_out;
  assign IllegalSticky = r_sticky;

endmodule

// File: tb/tb_control_unit.sv
// ---------------------------------------------------------------------------
// tb_control_unit
// Self-checking bench for control_unit. Expected {vector, Illegal} values
// are pushed to a scoreboard queue as each opcode is driven and popped when
// the outputs are sampled. Works for both builds of CONTROL_UNIT_OUT_REG_EN.
// ---------------------------------------------------------------------------
module tb_control_unit;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] Op    = 7'b0110011;
  logic RegDst, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch;
  logic ALUOp1, ALUOp0, Illegal, IllegalSticky;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [6:0] op;
    logic [9:0] exp;
  } sb_t;
  sb_t sb_q[$];

  control_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .Op            (Op),
    .RegDst        (RegDst),
    .ALUSrc        (ALUSrc),
    .MemToReg      (MemToReg),
    .RegWrite      (RegWrite),
    .MemRead       (MemRead),
    .MemWrite      (MemWrite),
    .Branch        (Branch),
    .ALUOp1        (ALUOp1),
    .ALUOp0        (ALUOp0),
    .Illegal       (Illegal),
    .IllegalSticky (IllegalSticky)
  );

  always #5 clk = ~clk;

  wire [8:0] w_vec = {RegDst, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite,
                      Branch, ALUOp1, ALUOp0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference table: {vector, Illegal}.
  function automatic logic [9:0] model(input logic [6:0] op);
    case (op)
      7'b0110011: return {9'b100100010, 1'b0};
      7'b0000011: return {9'b011110000, 1'b0};
      7'b0100011: return {9'b010001000, 1'b0};
      7'b1100011: return {9'b000000101, 1'b0};
      default:    return {9'b000000000, 1'b1};
    endcase
  endfunction

  task automatic drive(input logic [6:0] op);
    sb_t e;
    @(negedge clk);
    Op    = op;
    e.op  = op;
    e.exp = model(op);
    sb_q.push_back(e);
  endtask

  task automatic settle();
`ifdef CONTROL_UNIT_OUT_REG_EN
    @(posedge clk);
    #1;
`else
    #1;
`endif
  endtask

  task automatic sample(input string tag);
    sb_t e;
    if (sb_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb_q.pop_front();
      check(tag, {22'd0, w_vec, Illegal}, {22'd0, e.exp});
    end
  endtask

  logic [6:0] legal_ops [4];
  string      legal_names [4];
  int         legal_cnt;
  int         rw_conflicts;

  initial begin
    legal_ops   = '{7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011};
    legal_names = '{"rtype", "load", "store", "branch"};

    #3;
    check("rst_sticky", {31'd0, IllegalSticky}, 32'd0);
`ifdef CONTROL_UNIT_OUT_REG_EN
    check("rst_outs_zero", {22'd0, w_vec, Illegal}, 32'd0);
`else
    check("rst_comb_rtype", {22'd0, w_vec, Illegal}, {22'd0, 9'b100100010, 1'b0});
`endif
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      drive(legal_ops[i]);
      settle();
      sample(legal_names[i]);
      check({legal_names[i], "_sticky"}, {31'd0, IllegalSticky}, 32'd0);
    end

`ifdef CONTROL_UNIT_OUT_REG_EN
    drive(7'b0000011);
    settle();
    sample("lat_load");
    @(negedge clk);
    Op = 7'b0100011;
    sb_q.push_back('{7'b0100011, model(7'b0100011)});
    #1;
    check("lat_hold_load", {22'd0, w_vec, Illegal}, {22'd0, 9'b011110000, 1'b0});
    @(posedge clk);
    #1;
    sample("lat_store");
`endif

    drive(7'b0010011);
    settle();
    sample("illegal_op");
    check("sticky_pre", {31'd0, IllegalSticky}, 32'd0);
    @(posedge clk);
    #1;
    check("sticky_set", {31'd0, IllegalSticky}, 32'd1);

    drive(7'b0110011);
    settle();
    sample("rtype_after_illegal");
    check("sticky_hold", {31'd0, IllegalSticky}, 32'd1);

    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("sticky_async_clr", {31'd0, IllegalSticky}, 32'd0);
`ifdef CONTROL_UNIT_OUT_REG_EN
    check("rst_mid_outs_zero", {22'd0, w_vec, Illegal}, 32'd0);
`else
    check("rst_mid_comb", {22'd0, w_vec, Illegal}, {22'd0, 9'b100100010, 1'b0});
`endif
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("sticky_after_rst", {31'd0, IllegalSticky}, 32'd0);

    legal_cnt    = 0;
    rw_conflicts = 0;
    for (int i = 0; i < 128; i++) begin
      drive(7'(i));
      settle();
      if (!Illegal) legal_cnt++;
      if (MemRead && MemWrite) rw_conflicts++;
      sample($sformatf("sweep_%0d", i));
    end
    check("sweep_legal_count", legal_cnt, 32'd4);
    check("sweep_rd_wr_excl", rw_conflicts, 32'd0);
    check("sweep_sticky", {31'd0, IllegalSticky}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
